// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch and imem
interface fetch_unit_if #(parameter int AW = 32);
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect, drop and decode hold
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redir_valid,
    input  logic [1:0]            PCSrc,
    input  logic [ADDR_WIDTH-1:0] pc_imm_target,
    input  logic [ADDR_WIDTH-1:0] jalr_target,
    fetch_unit_if.master          imem,
    input  logic                  id_stall,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  misalign
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  drop;
    logic [31:0]           buf_instr;
    logic                  redir;
    logic [ADDR_WIDTH-1:0] raw_target;
    logic [ADDR_WIDTH-1:0] target;
    logic                  pend;
    logic                  resp;
    logic                  load_mem;
    logic                  load_buf;
    logic [1:0]            next_state;

    assign redir      = redir_valid && (PCSrc == 2'b01 || PCSrc == 2'b10);
    assign raw_target = PCSrc == 2'b10 ? {jalr_target[ADDR_WIDTH-1:1], 1'b0} : pc_imm_target;
    assign target     = {raw_target[ADDR_WIDTH-1:2], 2'b00};
    // a request is in flight (or being granted now) whose response must be swallowed
    assign pend       = (state == S_WAIT && !imem.rvalid) || (state == S_REQ && imem.gnt);
    assign resp       = state == S_WAIT && imem.rvalid;
    assign load_mem   = resp && !drop && (!instr_valid || !id_stall);
    assign load_buf   = state == S_HOLD && !id_stall;
    // gating with rst_n keeps the bus quiet while reset is held
    assign imem.req   = rst_n && state == S_REQ;
    assign imem.addr  = fetch_pc;

    // next FSM state when no redirect is present
    always_comb begin
        next_state = state;
        case (state)
            S_REQ:   next_state = imem.gnt ? S_WAIT : S_REQ;
            S_WAIT:  next_state = imem.rvalid ? ((drop || load_mem) ? S_REQ : S_HOLD) : S_WAIT;
            S_HOLD:  next_state = id_stall ? S_HOLD : S_REQ;
            default: next_state = S_REQ;
        endcase
    end

    // fetch state, output slot, skid buffer and redirect handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            drop        <= 1'b0;
            buf_instr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            pc_plus4    <= '0;
            misalign    <= 1'b0;
        end else begin
            misalign <= redir && raw_target[1:0] != 2'b00;
            if (redir) begin
                fetch_pc    <= target;
                instr_valid <= 1'b0;
                drop        <= pend;
                state       <= pend ? S_WAIT : S_REQ;
            end else begin
                if (load_mem || load_buf) begin
                    instr       <= load_mem ? imem.rdata : buf_instr;
                    pc          <= fetch_pc;
                    pc_plus4    <= fetch_pc + ADDR_WIDTH'(4);
                    fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
                    instr_valid <= 1'b1;
                end else if (!id_stall) begin
                    instr_valid <= 1'b0;
                end
                if (resp && !drop && !load_mem)
                    buf_instr <= imem.rdata;
                if (resp)
                    drop <= 1'b0;
                state <= next_state;
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'hBFC00000, address of the first fetch after reset.
REQ-002 Parameter ADDR_WIDTH, 32, width of all PC/address signals.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 redir_valid  in  1  one-cycle strobe: resolved control-flow change from decode/execute.
REQ-007 PCSrc  in  2  redirect select: 00 sequential, 01 PC+Imm, 10 JALR, 11 reserved.
REQ-008 pc_imm_target  in  32  PC+ImmExt target for JAL/branch.
REQ-009 jalr_target  in  32  rs1+Imm target for JALR.
REQ-010 imem_req  out  1  instruction-memory request.
REQ-011 imem_addr  out  32  request address.
REQ-012 imem_gnt  in  1  memory accepted the request this cycle.
REQ-013 imem_rvalid  in  1  read data valid.
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 id_stall  in  1  decode cannot accept a new instruction.
REQ-016 instr_valid  out  1  instr/pc/pc_plus4 hold a valid fetched instruction.
REQ-017 instr  out  32  instruction to decode (op, funct3, funct7 fields).
REQ-018 pc  out  32  address of instr.
REQ-019 pc_plus4  out  32  pc+4, for JAL/JALR link write-back.
REQ-020 misalign  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Function
REQ-021 The block SHALL keep at most one imem request outstanding.
REQ-022 FSM states: REQ (imem_req=1), WAIT (granted, awaiting rvalid), HOLD (output full, decode stalled).
REQ-023 REQ -> WAIT on imem_gnt; imem_addr and imem_req SHALL stay stable until gnt.
REQ-024 WAIT -> REQ on imem_rvalid when output slot is free or drained the same cycle (!instr_valid || !id_stall); otherwise WAIT -> HOLD.
REQ-025 On accepted rvalid: instr<=imem_rdata, pc<=fetch_pc, pc_plus4<=fetch_pc+4, instr_valid<=1, fetch_pc<=fetch_pc+4.
REQ-026 Output slot SHALL be held unchanged while instr_valid && id_stall; instr_valid SHALL clear when consumed (!id_stall) with no new data arriving.
REQ-027 HOLD -> REQ when !id_stall; no new request SHALL issue while in HOLD.
REQ-028 Redirect target: PCSrc 01 -> pc_imm_target; 10 -> jalr_target with bit 0 cleared; 00/11 -> no redirect, strobe ignored.
REQ-029 Target bits [1:0] SHALL be forced to 00; misalign SHALL pulse the cycle after if original bits [1:0] != 00 (after JALR bit-0 clear).
REQ-030 On redirect: fetch_pc<=target, instr_valid<=0 (flush) regardless of id_stall, state -> REQ next cycle.
REQ-031 Redirect in REQ before gnt: imem_addr SHALL change to target next cycle; redirect coinciding with gnt counts as WAIT case.
REQ-032 Redirect in WAIT: a drop flag SHALL be set; the pending response SHALL be discarded; new request issues only after that rvalid returns.
REQ-033 Redirect coinciding with rvalid: response discarded, no drop flag set.
REQ-034 Redirect has priority over all other same-cycle events; a second redirect while drop is set replaces the target.
REQ-035 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-036 Latency: redirect at cycle N -> imem_req with target at N+1; rvalid at M -> instr_valid at M+1.

Reset
REQ-037 While rst_n=0: state=REQ, fetch_pc=RESET_PC, instr_valid=0, instr=0, pc=0, pc_plus4=0, misalign=0, drop=0, imem_req=0.
REQ-038 First cycle after release SHALL assert imem_req with imem_addr=RESET_PC.
REQ-039 Reset asserted mid-WAIT SHALL discard the pending response; an rvalid in the first cycle after release SHALL be ignored.

Verification
REQ-040 Reset release, gnt same cycle, rvalid next, data 32'h00500093 -> instr_valid=1, instr=32'h00500093, pc=32'hBFC00000, pc_plus4=32'hBFC00004.
REQ-041 id_stall held 3 cycles with valid instr -> outputs unchanged, no imem_req in HOLD; release -> request at pc+4.
REQ-042 Redirect PCSrc=01, pc_imm_target=32'hBFC00040 in WAIT -> returning rvalid dropped, next imem_addr=32'hBFC00040, instr_valid=0 until that response.
REQ-043 Redirect PCSrc=10, jalr_target=32'hBFC00103 -> imem_addr=32'hBFC00100, misalign pulses once.
REQ-044 fetch_pc=32'hFFFFFFFC fetched -> pc_plus4=0, next imem_addr=0.
REQ-045 Redirect and rvalid same cycle with id_stall=1 -> instr_valid=0 next cycle, request to target.
